wb_write_arbiter: RTL and testbench

- Owns the single register-file write port (rd_addr/rd_data/wen) and merges two result sources onto it: the in-order pipeline WB stage and the iterative M-extension mul/div unit.
- Mul/div results are buffered in a small FIFO with a valid/ready handshake.
- A per-register busy scoreboard lets decode detect RAW hazards on outstanding mul/div destinations.
- Sits between WB/mul-div and the register file.

---
 rtl/rv_wb_pkg.sv | 14 +
 rtl/wb_result_fifo.sv | 55 +++++
 rtl/wb_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_wb_pkg.sv
// Shared register-address constants and the default write-back entry layout
// for the write-back arbiter slice.
package rv_wb_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;
   localparam int unsigned WB_XLEN = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_XLEN-1:0]    data;
   } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO holding mul/div results awaiting the register-file write
// port. DEPTH must be a power of two so the pointers wrap naturally.
module wb_result_fifo
   import rv_wb_pkg::*;
#(
   parameter type         entry_t = wb_entry_t,
   parameter int unsigned DEPTH   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  entry_t                 wr_entry,
   output entry_t                 rd_entry,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign rd_entry = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs buffered mul/div results,
// with busy scoreboard and starvation stall. `WB_FWD_EN adds bypass outputs.
module wb_write_arbiter
   import rv_wb_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipe_wen,
   input  logic [REG_ADDR_W-1:0] pipe_rd,
   input  logic [XLEN-1:0]       pipe_data,
   input  logic                  md_valid,
   output logic                  md_ready,
   input  logic [REG_ADDR_W-1:0] md_rd,
   input  logic [XLEN-1:0]       md_data,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  stall_req,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic [XLEN-1:0]       rd_data,
`ifdef WB_FWD_EN
   output logic                  rs1_fwd_hit,
   output logic                  rs2_fwd_hit,
   output logic [XLEN-1:0]       fwd_data,
`endif
   output logic                  wen
);

   localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
   localparam int unsigned NREGS    = 1 << REG_ADDR_W;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } entry_t;

   entry_t              push_entry;
   entry_t              head;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic                pipe_req;
   logic                pop;
   logic                md_push;
   logic                clr_en;
   logic                set_en;
   logic [NREGS-1:0]    busy;
   logic [NREGS-1:0]    busy_nxt;
   logic [STARVE_W-1:0] starve_cnt;
   logic [STARVE_W-1:0] starve_nxt;

   assign pipe_req   = pipe_wen && (pipe_rd != X0);
   assign pop        = !fifo_empty && !pipe_req;
   assign md_ready   = !fifo_full;
   assign md_push    = md_valid && md_ready;
   assign push_entry = {md_rd, md_data};
   // An x0 entry is still popped, it just never reaches the write port.
   assign clr_en     = pop && (head.rd != X0);
   assign set_en     = issue_valid && (issue_rd != X0);

   wb_result_fifo #(
      .entry_t (entry_t),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (md_push),
      .pop      (pop),
      .wr_entry (push_entry),
      .rd_entry (head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign rs1_busy = (rs1_addr != X0) && busy[rs1_addr];
   assign rs2_busy = (rs2_addr != X0) && busy[rs2_addr];

   always_comb begin
      busy_nxt = busy;
      if (clr_en) busy_nxt[head.rd] = 1'b0;
      if (set_en) busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_comb begin
      starve_nxt = starve_cnt;
      if (fifo_empty || pop)
         starve_nxt = '0;
      else if (starve_cnt != STARVE_W'(STARVE_MAX))
         starve_nxt = starve_cnt + STARVE_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr    <= '0;
         rd_data    <= '0;
         wen        <= 1'b0;
         busy       <= '0;
         starve_cnt <= '0;
         stall_req  <= 1'b0;
      end else begin
         busy       <= busy_nxt;
         starve_cnt <= starve_nxt;
         stall_req  <= (starve_nxt == STARVE_W'(STARVE_MAX));
         if (pipe_req) begin
            wen     <= 1'b1;
            rd_addr <= pipe_rd;
            rd_data <= pipe_data;
         end else if (clr_en) begin
            wen     <= 1'b1;
            rd_addr <= head.rd;
            rd_data <= head.data;
         end else begin
            wen     <= 1'b0;
         end
      end
   end

`ifdef WB_FWD_EN
   assign rs1_fwd_hit = wen && (rs1_addr == rd_addr) && (rs1_addr != X0);
   assign rs2_fwd_hit = wen && (rs2_addr == rd_addr) && (rs2_addr != X0);
   assign fwd_data    = rd_data;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         // Re-issuing a register whose pending write retires this same cycle is legal.
         assert (!(set_en && busy[issue_rd] && !(clr_en && head.rd == issue_rd)))
            else $error("wb_write_arbiter: issue to busy register x%0d", issue_rd);
         assert (!(pipe_req && busy[pipe_rd]))
            else $error("wb_write_arbiter: pipeline WAW on busy register x%0d", pipe_rd);
         assert (!(pipe_wen && stall_req))
            else $error("wb_write_arbiter: pipe_wen asserted during stall_req");
         assert (fifo_count <= CNT_W'(FIFO_DEPTH))
            else $error("wb_write_arbiter: result FIFO count overflow");
      end
   end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter; expected register-file
// writes are queued at drive time and matched when wen appears.
module tb_wb_write_arbiter;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            pipe_wen;
   logic [4:0]      pipe_rd;
   logic [XLEN-1:0] pipe_data;
   logic            md_valid;
   logic            md_ready;
   logic [4:0]      md_rd;
   logic [XLEN-1:0] md_data;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            stall_req;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rd_data;
   logic            wen;
`ifdef WB_FWD_EN
   logic            rs1_fwd_hit;
   logic            rs2_fwd_hit;
   logic [XLEN-1:0] fwd_data;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [36:0] pipe_q [$];
   logic [36:0] md_q   [$];
   logic [36:0] mon_e;
   logic        prev_pipe = 1'b0;

   wb_write_arbiter #(
      .XLEN       (XLEN),
      .FIFO_DEPTH (2),
      .STARVE_MAX (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pipe_wen    (pipe_wen),
      .pipe_rd     (pipe_rd),
      .pipe_data   (pipe_data),
      .md_valid    (md_valid),
      .md_ready    (md_ready),
      .md_rd       (md_rd),
      .md_data     (md_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .stall_req   (stall_req),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
`ifdef WB_FWD_EN
      .rs1_fwd_hit (rs1_fwd_hit),
      .rs2_fwd_hit (rs2_fwd_hit),
      .fwd_data    (fwd_data),
`endif
      .wen         (wen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] data);
      pipe_wen  = 1'b1;
      pipe_rd   = rd;
      pipe_data = data;
      if (rd != 5'd0) pipe_q.push_back({rd, data});
   endtask

   task automatic drive_md(input logic [4:0] rd, input logic [31:0] data, input logic will_write);
      md_valid = 1'b1;
      md_rd    = rd;
      md_data  = data;
      if (will_write && rd != 5'd0) md_q.push_back({rd, data});
   endtask

   // A pipeline request always owns the next write; otherwise any write is a FIFO pop.
   always @(posedge clk) prev_pipe <= !rst && pipe_wen && (pipe_rd != 5'd0);

   always @(negedge clk) begin
      if (!rst) begin
         if (prev_pipe) begin
            if (pipe_q.size() == 0) chk("pipe_q_underflow", 64'(pipe_q.size()), 64'd1);
            else begin
               mon_e = pipe_q.pop_front();
               chk("pipe_wen",  64'(wen), 64'd1);
               chk("pipe_addr", 64'(rd_addr), 64'(mon_e[36:32]));
               chk("pipe_data", 64'(rd_data), 64'(mon_e[31:0]));
            end
         end else if (wen === 1'b1) begin
            if (md_q.size() == 0) chk("unexpected_wen", 64'(wen), 64'd0);
            else begin
               mon_e = md_q.pop_front();
               chk("md_addr", 64'(rd_addr), 64'(mon_e[36:32]));
               chk("md_data", 64'(rd_data), 64'(mon_e[31:0]));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      pipe_wen = 1'b0; pipe_rd = '0; pipe_data = '0;
      md_valid = 1'b0; md_rd = '0; md_data = '0;
      issue_valid = 1'b0; issue_rd = '0;
      rs1_addr = '0; rs2_addr = '0;
      step();
      step();
      chk("rst_wen",      64'(wen), 64'd0);
      chk("rst_rd_addr",  64'(rd_addr), 64'd0);
      chk("rst_rd_data",  64'(rd_data), 64'd0);
      chk("rst_md_ready", 64'(md_ready), 64'd1);
      chk("rst_stall",    64'(stall_req), 64'd0);
      rst = 1'b0;
      step();

      // pipeline-only write, then pipe_rd=0 treated as no request
      drive_pipe(5'd3, 32'hDEADBEEF);
      step();
      chk("t1_wen",  64'(wen), 64'd1);
      chk("t1_addr", 64'(rd_addr), 64'd3);
      chk("t1_data", 64'(rd_data), 64'hDEADBEEF);
`ifdef WB_FWD_EN
      rs2_addr = 5'd3;
      #1;
      chk("fwd_hit",  64'(rs2_fwd_hit), 64'd1);
      chk("fwd_data", 64'(fwd_data), 64'hDEADBEEF);
      rs2_addr = 5'd0;
      #1;
      chk("fwd_hit_x0", 64'(rs2_fwd_hit), 64'd0);
`endif
      drive_pipe(5'd0, 32'h55);
      step();
      pipe_wen = 1'b0;
      chk("x0_wen",  64'(wen), 64'd0);
      chk("x0_hold", 64'(rd_addr), 64'd3);

      // mul/div round trip with scoreboard
      issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;
      step();
      issue_valid = 1'b0;
      chk("busy7_set", 64'(rs1_busy), 64'd1);
      chk("busy_rs0",  64'(rs2_busy), 64'd0);
      drive_md(5'd7, 32'h12, 1'b1);
      step();
      md_valid = 1'b0;
      chk("md_lat1_wen", 64'(wen), 64'd0);
      chk("busy7_hold",  64'(rs1_busy), 64'd1);
      step();
      chk("md_wen",     64'(wen), 64'd1);
      chk("md_addr7",   64'(rd_addr), 64'd7);
      chk("md_data12",  64'(rd_data), 64'h12);
      chk("busy7_clr",  64'(rs1_busy), 64'd0);
      step();
      chk("md_idle", 64'(wen), 64'd0);

      // same-cycle set and clear on x9
      issue_valid = 1'b1; issue_rd = 5'd9; rs1_addr = 5'd9;
      step();
      issue_valid = 1'b0;
      drive_md(5'd9, 32'h99, 1'b1);
      step();
      md_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9;
      step();
      issue_valid = 1'b0;
      chk("setclr_wen",  64'(wen), 64'd1);
      chk("setclr_busy", 64'(rs1_busy), 64'd1);
      step();

      // FIFO full under continuous pipeline traffic, then starvation stall
      drive_pipe(5'd10, 32'hA0); drive_md(5'd20, 32'hA, 1'b1);
      step();
      chk("full_rdy1", 64'(md_ready), 64'd1);
      drive_pipe(5'd11, 32'hA1); drive_md(5'd21, 32'hB, 1'b1);
      step();
      chk("full_rdy0", 64'(md_ready), 64'd0);
      drive_pipe(5'd12, 32'hA2); drive_md(5'd22, 32'hC, 1'b0);
      step();
      md_valid = 1'b0;
      chk("full_rdy_hold", 64'(md_ready), 64'd0);
      chk("stall_c2",      64'(stall_req), 64'd0);
      drive_pipe(5'd13, 32'hA3);
      step();
      chk("stall_c3", 64'(stall_req), 64'd0);
      drive_pipe(5'd14, 32'hA4);
      step();
      chk("stall_c4", 64'(stall_req), 64'd1);
      pipe_wen = 1'b0;
      chk("full_rdy_pop", 64'(md_ready), 64'd0);
      step();
      chk("stall_drop", 64'(stall_req), 64'd0);
      chk("starve_wen", 64'(wen), 64'd1);
      chk("starve_addr", 64'(rd_addr), 64'd20);
      chk("starve_rdy", 64'(md_ready), 64'd1);
      step();
      chk("drain_addr", 64'(rd_addr), 64'd21);
      step();
      chk("drain_done", 64'(wen), 64'd0);

      // FIFO entry for x0 is consumed silently
      drive_md(5'd0, 32'h77, 1'b1);
      step();
      md_valid = 1'b0;
      step();
      chk("x0pop_wen",  64'(wen), 64'd0);
      chk("x0pop_addr", 64'(rd_addr), 64'd21);
      chk("x0pop_data", 64'(rd_data), 64'hB);
      step();
      chk("x0pop_rdy", 64'(md_ready), 64'd1);

      // reset mid-operation with two buffered entries and x5 busy
      issue_valid = 1'b1; issue_rd = 5'd5; rs1_addr = 5'd5;
      step();
      issue_valid = 1'b0;
      drive_pipe(5'd1, 32'h100); drive_md(5'd5, 32'h50, 1'b0);
      step();
      drive_pipe(5'd2, 32'h200); drive_md(5'd5, 32'h51, 1'b0);
      step();
      pipe_wen = 1'b0; md_valid = 1'b0;
      chk("pre_rst_rdy",  64'(md_ready), 64'd0);
      chk("pre_rst_busy", 64'(rs1_busy), 64'd1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      step();
      chk("mid_rst_wen",  64'(wen), 64'd0);
      chk("mid_rst_rdy",  64'(md_ready), 64'd1);
      chk("mid_rst_busy", 64'(rs1_busy), 64'd0);
      chk("mid_rst_addr", 64'(rd_addr), 64'd0);
      rst = 1'b0;
      step();
      step();
      chk("post_rst_wen", 64'(wen), 64'd0);
      chk("post_rst_rdy", 64'(md_ready), 64'd1);
      step();

      chk("pipe_q_drained", 64'(pipe_q.size()), 64'd0);
      chk("md_q_drained",   64'(md_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
